// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and FSM encoding for the instruction-memory loader
package imem_loader_pkg;

  localparam int          BYTE_W       = 8;
  localparam logic [31:0] BUBBLE_INSTR = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - word RAM, one synchronous write port and one asynchronous read port
module imem_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  // Contents are deliberately not reset so a reset keeps the loaded program.
  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader wrapping imem_ram; IMEM_LOADER_CHECKSUM_EN adds a CHECK state
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int PC_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_SIZE-1:0] PCF,
  output logic [31:0]        RD,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [BYTE_W-1:0]  ld_byte,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               CpuHold,
  output logic               ld_err
);

  localparam logic [PC_SIZE-1:0] LAST_ADDR = {PC_SIZE{1'b1}};

  logic [1:0]         state_q, state_d;
  logic [PC_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        word_q, word_d;
  logic               full_q, full_d;
  logic               err_q, err_d;
  logic               accept;
  logic               mem_we;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]  csum_q, csum_d;
`endif

  assign accept = ld_valid && ld_ready;

  // Big-endian assembly; bytes not yet received read as zero, which gives the pad.
  always_comb begin
    case (byte_idx_q)
      2'd0:    mem_wdata = {ld_byte, 24'h0};
      2'd1:    mem_wdata = {word_q[23:16], ld_byte, 16'h0};
      2'd2:    mem_wdata = {word_q[23:8], ld_byte, 8'h0};
      default: mem_wdata = {word_q, ld_byte};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    full_d     = full_q;
    err_d      = err_q;
    mem_we     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          state_d    = ST_LOAD;
          wr_ptr_d   = '0;
          byte_idx_d = '0;
          full_d     = 1'b0;
          err_d      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ ld_byte;
`endif
          if (full_q) begin
            err_d = 1'b1;
          end else if (byte_idx_q == 2'd3 || ld_last) begin
            mem_we     = 1'b1;
            byte_idx_d = '0;
            if (byte_idx_q != 2'd3) begin
              err_d = 1'b1;
            end
            // The pointer parks on the last word; full_q then blocks any wrap.
            if (wr_ptr_q == LAST_ADDR) begin
              full_d = 1'b1;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0:    word_d[23:16] = ld_byte;
              2'd1:    word_d[15:8]  = ld_byte;
              default: word_d[7:0]   = ld_byte;
            endcase
          end
          if (ld_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          if (ld_byte != csum_q) begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      full_q     <= full_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  imem_ram #(
    .AW (PC_SIZE)
  ) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (mem_wdata),
    .raddr_i (PCF),
    .rdata_o (mem_rdata)
  );

  assign ld_ready = (state_q != ST_IDLE);
  assign CpuHold  = (state_q != ST_IDLE);
  assign ld_err   = err_q;
  assign RD       = (state_q == ST_IDLE) ? mem_rdata : BUBBLE_INSTR;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench for imem_loader; IMEM_LOADER_CHECKSUM_EN enables checksum scenarios
module tb_imem_loader;

  localparam int PCW   = 4;
  localparam int DEPTH = 2**PCW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [PCW-1:0] PCF = '0;
  logic [31:0]    RD;
  logic           ld_start = 1'b0;
  logic           ld_valid = 1'b0;
  logic [7:0]     ld_byte = 8'h00;
  logic           ld_last = 1'b0;
  logic           ld_ready;
  logic           CpuHold;
  logic           ld_err;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] tb_xor  = 8'h00;

  imem_loader #(.PC_SIZE(PCW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .PCF      (PCF),
    .RD       (RD),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .CpuHold  (CpuHold),
    .ld_err   (ld_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    tb_xor   = 8'h00;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tb_xor   = tb_xor ^ b;
  endtask

  task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    ld_valid = 1'b1;
    ld_byte  = tb_xor;
    tick();
    ld_valid = 1'b0;
`endif
  endtask

  task automatic check_word(input string name, input logic [PCW-1:0] a, input logic [31:0] exp);
    PCF = a;
    #1;
    n_tests++;
    if (RD !== exp) begin
      n_fail++;
      $display("FAIL %s: RD=%h expected %h", name, RD, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (CpuHold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b expected 0", CpuHold); end
    n_tests++;
    if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ld_ready); end
    n_tests++;
    if (ld_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", ld_err); end
  endtask

  task automatic test_load_word();
    do_start();
    PCF = '0;
    #1;
    n_tests++;
    if (CpuHold !== 1'b1 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_hold_ready: hold=%b ready=%b expected 1 1", CpuHold, ld_ready);
    end
    n_tests++;
    if (RD !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL load_bubble: RD=%h expected ffffffff", RD); end
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    send(8'h78, 1'b1);
    finish_load();
    n_tests++;
    if (CpuHold !== 1'b0) begin n_fail++; $display("FAIL load_release: hold=%b expected 0", CpuHold); end
    check_word("load_word0", 0, 32'h1234_5678);
    n_tests++;
    if (ld_err !== 1'b0) begin n_fail++; $display("FAIL load_err: got %b expected 0", ld_err); end
  endtask

  task automatic test_short();
    do_start();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    finish_load();
    check_word("short_pad", 0, 32'hAABB_0000);
    n_tests++;
    if (ld_err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b expected 1", ld_err); end
  endtask

  task automatic test_back_to_back();
    do_start();
    n_tests++;
    if (ld_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err_clear: got %b expected 0", ld_err); end
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    ld_start = 1'b1;
    send(8'h55, 1'b0);
    ld_start = 1'b0;
    PCF = 1;
    #1;
    n_tests++;
    if (RD !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_bubble: RD=%h expected ffffffff", RD); end
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b1);
    finish_load();
    check_word("b2b_word0", 0, 32'h1122_3344);
    check_word("b2b_word1", 1, 32'h5566_7788);
    n_tests++;
    if (ld_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b expected 0", ld_err); end
  endtask

  task automatic test_overflow();
    do_start();
    for (int i = 0; i < 4*DEPTH + 4; i++) begin
      send(8'(i), (i == 4*DEPTH + 3));
    end
    finish_load();
    for (int w = 0; w < DEPTH; w++) begin
      check_word("ovf_word", PCW'(w), {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
    end
    check_word("ovf_word0_kept", 0, 32'h0001_0203);
    n_tests++;
    if (ld_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", ld_err); end
  endtask

  task automatic test_reset_midload();
    do_start();
    for (int i = 0; i < 6; i++) begin
      send(8'hA1 + 8'(i), 1'b0);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (CpuHold !== 1'b0 || ld_ready !== 1'b0 || ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl: hold=%b ready=%b err=%b expected 0 0 0", CpuHold, ld_ready, ld_err);
    end
    check_word("midrst_word0", 0, 32'hA1A2_A3A4);
    check_word("midrst_word1", 1, 32'h0405_0607);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_start();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    n_tests++;
    if (ld_ready !== 1'b1 || CpuHold !== 1'b1) begin
      n_fail++;
      $display("FAIL csum_check_state: ready=%b hold=%b expected 1 1", ld_ready, CpuHold);
    end
    send(8'h04, 1'b0);
    n_tests++;
    if (ld_err !== 1'b0 || CpuHold !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_good: err=%b hold=%b expected 0 0", ld_err, CpuHold);
    end
    check_word("csum_word0", 0, 32'h0102_0304);
    do_start();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    send(8'h05, 1'b0);
    n_tests++;
    if (ld_err !== 1'b1 || CpuHold !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_bad: err=%b hold=%b expected 1 0", ld_err, CpuHold);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_word();
    test_short();
    test_back_to_back();
    test_overflow();
    test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
